clk_enable_gen: RTL and testbench



---
 rtl/clk_enable_gen.sv | 144 ++++++++++++++
 tb/tb_clk_enable_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator.
// Each channel is a phase accumulator (NCO). The carry out of the add is a
// single-cycle tick enable. Ticks are held off until pll_locked has been
// stable for LOCK_COUNT cycles after the two-flop synchroniser.
module clk_enable_gen #(
  parameter int NUM_CHANNELS = 2,
  parameter int ACC_WIDTH    = 32,
  parameter int LOCK_COUNT   = 1024,
  parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] INIT_INCR = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pll_locked,
  input  logic [NUM_CHANNELS-1:0] chan_en,
  input  logic                    sync,
  input  logic                    cfg_wr_en,
  input  logic [2:0]              cfg_chan,
  input  logic [ACC_WIDTH-1:0]    cfg_incr,
  output logic [NUM_CHANNELS-1:0] tick,
  output logic                    ready
);

  // The stabilise counter only has to reach LOCK_COUNT-1.
  localparam int CNT_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_locked_s;
  logic             r_ready;

  logic w_in_run;
  logic w_clear;
  logic w_advance;

  // Two-flop synchroniser for the asynchronous PLL lock indicator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Lock qualifier FSM; ready is registered as a decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_ready <= 1'b0;
          r_cnt   <= '0;
          if (r_locked_s) begin
            r_state <= STABILISE;
          end
        end
        STABILISE: begin
          if (!r_locked_s) begin
            r_state <= WAIT_LOCK;
            r_ready <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          if (!r_locked_s) begin
            r_state <= WAIT_LOCK;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Losing lock while running, or a sync request, zeroes every accumulator
  // on the same edge. Outside RUN the accumulators are already zero.
  assign w_in_run  = (r_state == RUN);
  assign w_clear   = w_in_run && (!r_locked_s || sync);
  assign w_advance = w_in_run && !w_clear;

  assign ready = r_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic [ACC_WIDTH-1:0] r_acc;
      logic [ACC_WIDTH-1:0] r_incr;
      logic                 r_tick;
      logic [ACC_WIDTH:0]   w_sum;

      // The carry out of this add is the tick.
      assign w_sum    = {1'b0, r_acc} + {1'b0, r_incr};
      assign tick[gi] = r_tick;

      // Increment register; a write never touches the accumulator.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_incr <= INIT_INCR[gi*ACC_WIDTH +: ACC_WIDTH];
        end else if (cfg_wr_en && (cfg_chan == 3'(gi))) begin
          r_incr <= cfg_incr;
        end
      end

      // Phase accumulator: clear, advance, or hold with tick low.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_acc  <= '0;
          r_tick <= 1'b0;
        end else if (w_clear) begin
          r_acc  <= '0;
          r_tick <= 1'b0;
        end else if (w_advance && chan_en[gi]) begin
          r_acc  <= w_sum[ACC_WIDTH-1:0];
          r_tick <= w_sum[ACC_WIDTH];
        end else begin
          r_tick <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against an arithmetic model of the lock qualifier and the accumulators.
module tb_clk_enable_gen;

  localparam int NCH  = 2;
  localparam int ACCW = 8;
  localparam int LOCK = 4;
  localparam int MODV = 1 << ACCW;
  localparam logic [NCH*ACCW-1:0] INIT = 16'h0040;  // ch1 = 0, ch0 = 64

  logic            clk = 1'b0;
  logic            reset;
  logic            pll_locked;
  logic [NCH-1:0]  chan_en;
  logic            sync;
  logic            cfg_wr_en;
  logic [2:0]      cfg_chan;
  logic [ACCW-1:0] cfg_incr;
  logic [NCH-1:0]  tick;
  logic            ready;

  int n_checks = 0;
  int n_err    = 0;

  clk_enable_gen #(
    .NUM_CHANNELS(NCH),
    .ACC_WIDTH   (ACCW),
    .LOCK_COUNT  (LOCK),
    .INIT_INCR   (INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .chan_en   (chan_en),
    .sync      (sync),
    .cfg_wr_en (cfg_wr_en),
    .cfg_chan  (cfg_chan),
    .cfg_incr  (cfg_incr),
    .tick      (tick),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the lock history is a plain record of pll_locked as
  // sampled on past edges; the generator runs once the synchronised lock
  // has been seen high on LOCK+1 consecutive edges.
  bit       m_hist1, m_hist2;   // pll_locked sampled 1 and 2 edges ago
  int       m_run_len;
  int       m_acc [NCH];
  int       m_incr[NCH];
  bit [1:0] m_tick;
  bit       m_ready;
  bit       m_l;
  bit       m_run_before;
  int       m_sum;
  int       m_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_hist1   = 1'b0;
      m_hist2   = 1'b0;
      m_run_len = 0;
      m_tick    = '0;
      for (int c = 0; c < NCH; c++) begin
        m_acc[c]  = 0;
        m_incr[c] = int'(INIT[c*ACCW +: ACCW]);
      end
    end else begin
      m_l          = m_hist2;
      m_run_before = (m_run_len >= LOCK + 1);
      for (int c = 0; c < NCH; c++) begin
        if (m_run_before && (!m_l || sync)) begin
          m_acc[c]  = 0;
          m_tick[c] = 1'b0;
        end else if (m_run_before && chan_en[c]) begin
          m_sum     = m_acc[c] + m_incr[c];
          m_tick[c] = (m_sum >= MODV);
          m_acc[c]  = m_sum % MODV;
        end else begin
          m_tick[c] = 1'b0;
        end
      end
      if (m_l) begin
        if (m_run_len < 100000) m_run_len++;
      end else begin
        m_run_len = 0;
      end
      m_idx = int'(cfg_chan);
      if (cfg_wr_en && m_idx < NCH) m_incr[m_idx] = int'(cfg_incr);
      m_hist2 = m_hist1;
      m_hist1 = pll_locked;
    end
    m_ready = (m_run_len >= LOCK + 1);
    #1;
    chk("model_ready", 32'(ready), 32'(m_ready));
    chk("model_tick", 32'(tick), 32'(m_tick));
  end

  int cnt0, cnt1;
  int low_left;

  initial begin
    reset = 1'b1; pll_locked = 1'b0; chan_en = '0; sync = 1'b0;
    cfg_wr_en = 1'b0; cfg_chan = '0; cfg_incr = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_tick", 32'(tick), 0);

    // Lock comes up before edge 1: ready rises after edge LOCK+3 = 7.
    reset = 1'b0; pll_locked = 1'b1; chan_en = 2'b01;
    repeat (6) @(negedge clk);
    chk("ready_edge6", 32'(ready), 0);
    @(negedge clk);
    chk("ready_edge7", 32'(ready), 1);

    // incr=64: acc 64,128,192,0 -> tick after the 4th RUN edge.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("ch0_incr64_tick", 32'(tick[0]), 32'(k == 4));
    end

    // incr=96 on ch0 gives 9 ticks in 24 cycles; ch1 incr=0 never ticks.
    cfg_wr_en = 1'b1; cfg_chan = 3'd0; cfg_incr = 8'd96; chan_en = 2'b11;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (tick[0]) cnt0++;
      if (tick[1]) cnt1++;
    end
    chk("ch0_incr96_count", 32'(cnt0), 9);
    chk("ch1_incr0_count", 32'(cnt1), 0);

    // sync and write together, then retune 64->128 exactly when acc=128.
    sync = 1'b1; cfg_wr_en = 1'b1; cfg_chan = 3'd0; cfg_incr = 8'd64;
    @(negedge clk);
    sync = 1'b0; cfg_wr_en = 1'b0;
    chk("sync_edge_tick", 32'(tick), 0);
    @(negedge clk);
    chk("retune_k1", 32'(tick[0]), 0);
    cfg_wr_en = 1'b1; cfg_incr = 8'd128;
    @(negedge clk);
    chk("retune_k2", 32'(tick[0]), 0);
    cfg_wr_en = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      chk("retune_tick", 32'(tick[0]), 32'(k % 2 == 1));
    end

    // Out-of-range channel write must not alter any increment.
    cfg_wr_en = 1'b1; cfg_chan = 3'd5; cfg_incr = 8'd77;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    repeat (8) @(negedge clk);

    // Lose lock in RUN: ready falls after two synchroniser edges plus one.
    pll_locked = 1'b0;
    @(negedge clk);
    chk("drop_edge1_ready", 32'(ready), 1);
    @(negedge clk);
    chk("drop_edge2_ready", 32'(ready), 1);
    @(negedge clk);
    chk("drop_edge3_ready", 32'(ready), 0);
    chk("drop_edge3_tick", 32'(tick), 0);
    pll_locked = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("relock_ready", 32'(ready), 32'(k == 7));
    end

    // Phase alignment: ch0=64, ch1=32, sync -> ticks at +4 and +8.
    cfg_wr_en = 1'b1; cfg_chan = 3'd0; cfg_incr = 8'd64;
    @(negedge clk);
    cfg_chan = 3'd1; cfg_incr = 8'd32;
    @(negedge clk);
    cfg_wr_en = 1'b0; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("align_ch0", 32'(tick[0]), 32'(k % 4 == 0));
      chk("align_ch1", 32'(tick[1]), 32'(k % 8 == 0));
    end

    // Reset in the middle of running.
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_ready", 32'(ready), 0);
    chk("midrun_reset_tick", 32'(tick), 0);
    reset = 1'b0;

    // Randomized traffic, checked every cycle by the model.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      if (low_left > 0) begin
        low_left--;
        pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 249) == 0) begin
          low_left   = $urandom_range(0, 5);
          pll_locked = 1'b0;
        end
      end
      if ($urandom_range(0, 19) == 0) chan_en = 2'($urandom_range(0, 3));
      sync      = ($urandom_range(0, 39) == 0);
      cfg_wr_en = ($urandom_range(0, 9) == 0);
      cfg_chan  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       cfg_incr = 8'd0;
        1:       cfg_incr = 8'd128;
        default: cfg_incr = 8'($urandom_range(0, 255));
      endcase
    end
    reset = 1'b0; sync = 1'b0; cfg_wr_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
